regfile_mp: RTL

Parametrised multi-port register file for the CPU datapath: configurable data width, depth and read-port count, two prioritised write ports, and a per-register pending (scoreboard) bit. It is the general-register store between decode and writeback. Register 0 is hardwired to zero. The scoreboard lets the issue logic stall on operands whose producer has not yet written back.

---
 rtl/regfile_mp.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports and a per-register pending bit.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_pend,
  input  logic                           we0,
  input  logic [ADDR_WIDTH-1:0]          wa0,
  input  logic [DATA_WIDTH-1:0]          wd0,
  input  logic                           we1,
  input  logic [ADDR_WIDTH-1:0]          wa1,
  input  logic [DATA_WIDTH-1:0]          wd1,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic [ADDR_WIDTH:0]            pend_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_nxt;
  logic [ADDR_WIDTH:0]   cnt_nxt;

  // Reserve is applied after both write-side clears so the new producer wins.
  always_comb begin
    pend_nxt = pend;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (we0 && (wa0 == ADDR_WIDTH'(i)))
        pend_nxt[i] = 1'b0;
      if (we1 && (wa1 == ADDR_WIDTH'(i)))
        pend_nxt[i] = 1'b0;
      if (rsv_en && (rsv_addr == ADDR_WIDTH'(i)))
        pend_nxt[i] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, pend_nxt[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Port 1 is written last so it overrides port 0 on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else begin
      if (we0 && (wa0 != '0))
        regs[wa0] <= wd0;
      if (we1 && (wa1 != '0))
        regs[wa1] <= wd1;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic                  p;
    rd_data = '0;
    rd_pend = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      a = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      d = regs[a];
      p = pend[a];
`ifdef REGFILE_BYPASS_EN
      if (we0 && (wa0 == a)) begin
        d = wd0;
        p = 1'b0;
      end
      if (we1 && (wa1 == a)) begin
        d = wd1;
        p = 1'b0;
      end
      if (rsv_en && (rsv_addr == a))
        p = 1'b1;
`endif
      if (a == '0) begin
        d = '0;
        p = 1'b0;
      end
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
      rd_pend[i] = p;
    end
  end

endmodule
